step_move_ctrl: RTL and testbench

Motion sequencer for the 4-phase stepper drive path. Accepts move commands (direction plus step count) over a valid/ready handshake. Emits single-cycle step strobes and a direction level to the phase sequencer, with a linear-period trapezoidal speed ramp (accelerate, cruise, decelerate). Tracks signed absolute position, supports abort, and reports completion with a one-cycle done pulse.

---
 rtl/stepper_pkg.sv | 21 ++
 rtl/step_rate_gen.sv | 60 ++++++
 rtl/step_move_ctrl.sv | 124 ++++++++++++
 tb/tb_step_move_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper drive path: move-FSM encoding, default timing and phase table.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] PERIOD_START_DEF  = 32'd200000;
    localparam logic [31:0] PERIOD_MIN_DEF    = 32'd50000;
    localparam logic [31:0] RAMP_STEP_DEF     = 32'd2000;
    localparam logic [31:0] SETTLE_CYCLES_DEF = 32'd1000;
    localparam int unsigned STEPS_W_DEF       = 16;
    localparam int unsigned POS_W_DEF         = 24;

    // Full-step coil pattern {A, B, A-, B-} used by the phase sequencer, one entry per strobe.
    localparam logic [3:0][3:0] PHASE_TABLE = {4'b1001, 4'b0011, 4'b0110, 4'b1100};

endpackage

// File: rtl/step_rate_gen.sv
// Step-interval generator: tick counter, period register and trapezoidal ramp arithmetic.
module step_rate_gen
    import stepper_pkg::*;
#(
    parameter logic [31:0] PERIOD_START = PERIOD_START_DEF,
    parameter logic [31:0] PERIOD_MIN   = PERIOD_MIN_DEF,
    parameter logic [31:0] RAMP_STEP    = RAMP_STEP_DEF,
    parameter int unsigned STEPS_W      = STEPS_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               run,
    input  logic               stop,
    input  logic [STEPS_W-1:0] remaining,
    output logic               strobe_c
);

    logic [31:0]        tick;
    logic [31:0]        period;
    logic [31:0]        period_up;
    logic [31:0]        period_dn;
    logic [STEPS_W-1:0] ramp_cnt;
    logic [STEPS_W-1:0] rem_next;

    assign rem_next = remaining - STEPS_W'(1);
    assign strobe_c = run && !stop && (tick == period - 32'd1);

    // Clamped ramp neighbours; period always lies in [PERIOD_MIN, PERIOD_START] while running.
    assign period_up = (PERIOD_START - period <= RAMP_STEP) ? PERIOD_START : period + RAMP_STEP;
    assign period_dn = (period - PERIOD_MIN <= RAMP_STEP) ? PERIOD_MIN : period - RAMP_STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick     <= 32'd0;
            period   <= 32'd0;
            ramp_cnt <= '0;
        end else if (start) begin
            // The accept cycle counts as the first tick, so the strobe register
            // fires PERIOD_START cycles after the accept cycle.
            tick     <= 32'd1;
            period   <= PERIOD_START;
            ramp_cnt <= '0;
        end else if (strobe_c) begin
            tick <= 32'd0;
            if (rem_next != '0) begin
                if (rem_next <= ramp_cnt) begin
                    period   <= period_up;
                    ramp_cnt <= ramp_cnt - STEPS_W'(1);
                end else if (period > PERIOD_MIN) begin
                    period   <= period_dn;
                    ramp_cnt <= ramp_cnt + STEPS_W'(1);
                end
            end
        end else if (run) begin
            tick <= tick + 32'd1;
        end
    end

endmodule

// File: rtl/step_move_ctrl.sv
// Move sequencer: accepts move commands, drives step strobes with a speed ramp, tracks position.
module step_move_ctrl
    import stepper_pkg::*;
#(
    parameter logic [31:0] PERIOD_START  = PERIOD_START_DEF,
    parameter logic [31:0] PERIOD_MIN    = PERIOD_MIN_DEF,
    parameter logic [31:0] RAMP_STEP     = RAMP_STEP_DEF,
    parameter logic [31:0] SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned STEPS_W       = STEPS_W_DEF,
    parameter int unsigned POS_W         = POS_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic               abort,
    input  logic               zero_pos,
    output logic               step_pulse,
    output logic               step_dir,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [POS_W-1:0]   position
);

    state_t             state;
    state_t             state_nx;
    logic [STEPS_W-1:0] remaining;
    logic [31:0]        settle_cnt;
    logic               accept_c;
    logic               strobe_c;
    logic               cmd_ready_nx;
    logic               busy_nx;
    logic               done_nx;

    assign accept_c = (state == ST_IDLE) && cmd_valid;

    step_rate_gen #(
        .PERIOD_START (PERIOD_START),
        .PERIOD_MIN   (PERIOD_MIN),
        .RAMP_STEP    (RAMP_STEP),
        .STEPS_W      (STEPS_W)
    ) u_rate (
        .clk       (clk),
        .rst       (rst),
        .start     (accept_c),
        .run       (state == ST_RUN),
        .stop      (abort),
        .remaining (remaining),
        .strobe_c  (strobe_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (cmd_valid) state_nx = (cmd_steps == '0) ? ST_DONE : ST_RUN;
            ST_RUN:    if (abort || (strobe_c && remaining == STEPS_W'(1))) state_nx = ST_SETTLE;
            ST_SETTLE: if (settle_cnt >= SETTLE_CYCLES - 32'd1) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // done trails the DONE state by one cycle; busy and cmd_ready follow the next state.
    always_comb begin
        cmd_ready_nx = 1'b0;
        busy_nx      = 1'b0;
        done_nx      = 1'b0;
        cmd_ready_nx = (state_nx == ST_IDLE);
        busy_nx      = (state_nx != ST_IDLE);
        done_nx      = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            cmd_ready  <= cmd_ready_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            step_pulse <= strobe_c;
        end
    end

    // Move datapath: command latch, remaining count, position, abort flag, settle timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_dir   <= 1'b0;
            remaining  <= '0;
            aborted    <= 1'b0;
            position   <= '0;
            settle_cnt <= 32'd0;
        end else begin
            if (state == ST_IDLE && zero_pos) position <= '0;
            if (accept_c) begin
                step_dir  <= cmd_dir;
                remaining <= cmd_steps;
                aborted   <= 1'b0;
            end
            if (state == ST_RUN) begin
                if (abort) begin
                    aborted <= 1'b1;
                end else if (strobe_c) begin
                    remaining <= remaining - STEPS_W'(1);
                    position  <= step_dir ? position + POS_W'(1) : position - POS_W'(1);
                end
            end
            // Settle time is measured from the cycle the last strobe is seen.
            if (state != ST_SETTLE && state_nx == ST_SETTLE) settle_cnt <= 32'd1;
            else if (state == ST_SETTLE)                     settle_cnt <= settle_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_step_move_ctrl.sv
// Self-checking bench for step_move_ctrl: vector table of moves plus reset/hold corner sequences.
`timescale 1ns/1ps
module tb_step_move_ctrl;

    localparam int SETTLE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = 16'd0;
    logic        abort = 1'b0;
    logic        zero_pos = 1'b0;
    logic        cmd_ready, step_pulse, step_dir, busy, done, aborted;
    logic [23:0] position;

    step_move_ctrl #(
        .PERIOD_START  (32'd10),
        .PERIOD_MIN    (32'd4),
        .RAMP_STEP     (32'd2),
        .SETTLE_CYCLES (32'd3),
        .STEPS_W       (16),
        .POS_W         (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .abort      (abort),
        .zero_pos   (zero_pos),
        .step_pulse (step_pulse),
        .step_dir   (step_dir),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .position   (position)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int iv;
        int pos;
        bit dir;
    } exp_t;

    typedef struct {
        bit dir;
        int steps;
        bit zero_cmd;
        int abort_after;
        bit hold;
        bit zmove;
        int end_pos;
        bit ab;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[6];
    int   ivt[6][20];
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_pos = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pos_i();
        return int'($signed(position));
    endfunction

    task automatic run_move(input int vi);
        vec_t v;
        exp_t e;
        int   acc, last, nstr, abort_cyc, base, n_exp, exp_done;
        bit   fin, ready_ok, dir_ok;
        v = vt[vi];
        n_exp = (v.abort_after > 0) ? v.abort_after : v.steps;
        @(negedge clk);
        check("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dir   = v.dir;
        cmd_steps = 16'(v.steps);
        zero_pos  = v.zero_cmd;
        acc  = cyc;
        base = v.zero_cmd ? 0 : model_pos;
        for (int k = 0; k < n_exp; k++) begin
            e.iv  = ivt[vi][k];
            e.pos = v.dir ? base + k + 1 : base - k - 1;
            e.dir = v.dir;
            sb_q.push_back(e);
        end
        @(negedge clk);
        zero_pos = 1'b0;
        if (v.hold) begin
            cmd_dir   = ~v.dir;
            cmd_steps = 16'd7;
        end else begin
            cmd_valid = 1'b0;
        end
        check("busy_after_accept", busy, 1);
        check("ready_low_busy", cmd_ready, 0);
        check("aborted_cleared", aborted, 0);
        last = acc; nstr = 0; abort_cyc = -1; fin = 0; ready_ok = 1; dir_ok = 1;
        for (int t = 0; t < 3000 && !fin; t++) begin
            if (t > 0) @(negedge clk);
            abort    = 1'b0;
            zero_pos = 1'b0;
            if (busy && cmd_ready) ready_ok = 0;
            if (busy && step_dir !== v.dir) dir_ok = 0;
            if (step_pulse) begin
                nstr++;
                if (sb_q.size() == 0) begin
                    check("extra_strobe", nstr, n_exp);
                end else begin
                    e = sb_q.pop_front();
                    check("interval", cyc - last, e.iv);
                    check("pos_at_strobe", pos_i(), e.pos);
                    check("dir_at_strobe", step_dir, e.dir);
                end
                last = cyc;
                if (nstr == v.abort_after) begin
                    abort     = 1'b1;
                    abort_cyc = cyc;
                end
                if (v.zmove && nstr == 1) zero_pos = 1'b1;
            end
            if (done) begin
                fin = 1;
                cmd_valid = 1'b0;
                if (v.steps == 0)        exp_done = acc + 2;
                else if (abort_cyc >= 0) exp_done = abort_cyc + 1 + SETTLE;
                else                     exp_done = last + SETTLE;
                check("done_time", cyc, exp_done);
                check("strobe_count", nstr, n_exp);
                check("end_pos", pos_i(), v.end_pos);
                check("aborted_flag", aborted, v.ab);
                check("busy_at_done", busy, 0);
                check("sb_empty", sb_q.size(), 0);
                check("ready_low_during_move", ready_ok, 1);
                check("dir_stable", dir_ok, 1);
            end
        end
        if (!fin) begin
            check("done_timeout", 0, 1);
            cmd_valid = 1'b0;
            sb_q.delete();
        end
        model_pos = v.end_pos;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        if (v.hold) begin
            repeat (3) @(negedge clk);
            check("held_cmd_ignored", busy, 0);
            check("held_no_move", pos_i(), v.end_pos);
        end
    endtask

    initial begin
        vt[0] = '{1'b1,  5, 1'b0, 0, 1'b0, 1'b0,   5, 1'b0};
        vt[1] = '{1'b0, 20, 1'b1, 0, 1'b0, 1'b0, -20, 1'b0};
        vt[2] = '{1'b1,  0, 1'b0, 0, 1'b0, 1'b0, -20, 1'b0};
        vt[3] = '{1'b1, 50, 1'b1, 7, 1'b0, 1'b0,   7, 1'b1};
        vt[4] = '{1'b1,  3, 1'b0, 0, 1'b1, 1'b1,  10, 1'b0};
        vt[5] = '{1'b1,  3, 1'b0, 0, 1'b0, 1'b0,   3, 1'b0};
        for (int i = 0; i < 6; i++)
            for (int k = 0; k < 20; k++) ivt[i][k] = 4;
        ivt[0][0] = 10; ivt[0][1] = 8; ivt[0][2] = 6; ivt[0][3] = 8; ivt[0][4] = 10;
        ivt[1][0] = 10; ivt[1][1] = 8; ivt[1][2] = 6;
        ivt[1][17] = 6; ivt[1][18] = 8; ivt[1][19] = 10;
        ivt[3][0] = 10; ivt[3][1] = 8; ivt[3][2] = 6;
        ivt[4][0] = 10; ivt[4][1] = 8; ivt[4][2] = 10;
        ivt[5][0] = 10; ivt[5][1] = 8; ivt[5][2] = 10;

        repeat (3) @(negedge clk);
        check("reset_outputs", {cmd_ready, step_pulse, step_dir, busy, done, aborted}, 0);
        check("reset_position", position, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", cmd_ready, 1);

        for (int i = 0; i < 5; i++) run_move(i);

        @(negedge clk);
        zero_pos = 1'b1;
        @(negedge clk);
        zero_pos = 1'b0;
        check("zero_pos_idle", pos_i(), 0);
        model_pos = 0;

        // Reset while running: 20-step move cut off after its second strobe.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd20;
        @(negedge clk);
        cmd_valid = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int t = 0; t < 200 && seen < 2; t++) begin
                @(negedge clk);
                if (step_pulse) seen++;
            end
            check("pre_reset_strobes", seen, 2);
        end
        rst = 1'b0;
        #1;
        check("midrun_reset_outputs", {cmd_ready, step_pulse, step_dir, busy, done, aborted}, 0);
        check("midrun_reset_pos", position, 0);
        repeat (2) @(negedge clk);
        check("no_done_in_reset", done, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_midrun_reset", cmd_ready, 1);
        run_move(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
